// File: rtl/rot_enc_decoder.sv
`default_nettype none
// ============================================================================
// Module  : rot_enc_decoder
// Brief   : Rotary-encoder front end. Synchronises and debounces A/B/PB,
//           decodes quadrature into CW/CCW steps and keeps a wrapping
//           position count. Define ROT_DETENT4_EN for one step per detent.
// Revision: 1.0 - initial release
// ============================================================================
module rot_enc_decoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               enc_pb,
    input  logic               pos_clr,
    output logic               step_cw,
    output logic               step_ccw,
    output logic               step_err,
    output logic [COUNT_W-1:0] pos,
    output logic               pb_level,
    output logic               pb_press
);

    localparam int               c_NCH      = 3;
    localparam int               c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    // Channel order {pb, b, a}: encoder idles on the 11 detent, button released.
    localparam logic [c_NCH-1:0] c_IDLE     = 3'b011;

    logic [c_NCH-1:0] w_raw;
    logic [c_NCH-1:0] w_deb;

    assign w_raw = {enc_pb, enc_b, enc_a};

    generate
        for (genvar g = 0; g < c_NCH; g++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_CNT_W-1:0]     r_cnt;
            logic                   r_deb;
            logic                   w_sync;

            assign w_sync = r_sync[SYNC_STAGES-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{c_IDLE[g]}};
                    r_cnt  <= '0;
                    r_deb  <= c_IDLE[g];
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
                    if (w_sync == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_deb <= w_sync;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            assign w_deb[g] = r_deb;
        end
    endgenerate

    // Quadrature state written {A,B}; CW walks 11 -> 01 -> 00 -> 10 -> 11.
    function automatic logic [1:0] f_cw_next(input logic [1:0] s);
        case (s)
            2'b11:   return 2'b01;
            2'b01:   return 2'b00;
            2'b00:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    logic [1:0] w_cur;
    logic [1:0] r_prev;
    logic       w_fwd;
    logic       w_rev;
    logic       w_err;
    logic       w_cw;
    logic       w_ccw;

    assign w_cur = {w_deb[0], w_deb[1]};
    assign w_fwd = (w_cur == f_cw_next(r_prev));
    assign w_rev = (r_prev == f_cw_next(w_cur));
    assign w_err = ((w_cur ^ r_prev) == 2'b11);

`ifdef ROT_DETENT4_EN
    logic signed [2:0] r_acc;
    logic signed [3:0] w_acc_ext;
    logic signed [3:0] w_delta;
    logic signed [3:0] w_acc_sum;
    logic              w_at_detent;

    // The sum is one bit wider so a full turn of +/-4 is visible before it wraps.
    assign w_acc_ext   = {r_acc[2], r_acc};
    assign w_delta     = w_fwd ? 4'sd1 : (w_rev ? -4'sd1 : 4'sd0);
    assign w_acc_sum   = w_acc_ext + w_delta;
    assign w_at_detent = (w_cur == 2'b11);
    assign w_cw        = w_fwd & w_at_detent & (w_acc_sum == 4'sd4);
    assign w_ccw       = w_rev & w_at_detent & (w_acc_sum == -4'sd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_err || ((w_fwd || w_rev) && w_at_detent)) begin
            r_acc <= '0;
        end else if (w_fwd || w_rev) begin
            r_acc <= w_acc_sum[2:0];
        end
    end
`else
    assign w_cw  = w_fwd;
    assign w_ccw = w_rev;
`endif

    logic               r_step_cw;
    logic               r_step_ccw;
    logic               r_step_err;
    logic [COUNT_W-1:0] r_pos;
    logic               r_pb_q;
    logic               r_pb_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= 2'b11;
            r_step_cw  <= 1'b0;
            r_step_ccw <= 1'b0;
            r_step_err <= 1'b0;
            r_pos      <= '0;
            r_pb_q     <= 1'b0;
            r_pb_press <= 1'b0;
        end else begin
            r_prev     <= w_cur;
            r_step_cw  <= w_cw;
            r_step_ccw <= w_ccw;
            r_step_err <= w_err;
            if (pos_clr) begin
                r_pos <= '0;
            end else if (w_cw) begin
                r_pos <= r_pos + COUNT_W'(1);
            end else if (w_ccw) begin
                r_pos <= r_pos - COUNT_W'(1);
            end
            r_pb_q     <= w_deb[2];
            r_pb_press <= w_deb[2] & ~r_pb_q;
        end
    end

    assign step_cw  = r_step_cw;
    assign step_ccw = r_step_ccw;
    assign step_err = r_step_err;
    assign pos      = r_pos;
    assign pb_level = w_deb[2];
    assign pb_press = r_pb_press;

endmodule
`default_nettype wire
